vmul_unit_seq: RTL and testbench

- Parametrised vector multiply unit for the vector lane datapath.
- Time-multiplexes NUMMULS physical multipliers across NUMLANES lanes, one lane group per cycle; stalls the lane pipeline while groups remain.
- New over the previous generation: groups whose vmask bits are all zero are skipped, so they cost no cycles; the high product half and a fixed-point rounding shift are available.
- Three pipe stages: operand/issue (1), multiply (2), shift/writeback (3).

---
 rtl/vmul_unit_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_vmul_unit_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vmul_unit_seq.sv
// vmul_unit_seq: vector multiply unit. NUMMULS physical multipliers are shared
// across NUMLANES lanes. One active lane group issues per cycle, and all-zero
// vmask groups are skipped. Pipe: issue (1), multiply register (2),
// shift/round and result assembly (3).
module vmul_unit_seq #(
    parameter int NUMLANES  = 8,
    parameter int NUMMULS   = 4,
    parameter int WIDTH     = 32,
    parameter int LOG2WIDTH = 5,
    parameter int REGIDBITS = 10
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [4:0]                op,
    input  logic                      activate,
    input  logic [3:1]                en,
    input  logic [3:1]                squash,
    input  logic [NUMLANES*WIDTH-1:0] opA,
    input  logic [NUMLANES*WIDTH-1:0] opB,
    input  logic [LOG2WIDTH-1:0]      vshamt,
    input  logic [NUMLANES-1:0]       vmask,
    input  logic [REGIDBITS-1:0]      in_dst,
    input  logic                      in_dst_we,
    output logic                      stall,
    output logic [NUMLANES*WIDTH-1:0] result,
    output logic [2*REGIDBITS-1:0]    out_dst,
    output logic [1:0]                out_dst_we,
    output logic [2*NUMLANES-1:0]     out_dst_mask
);
    localparam int G  = NUMLANES / NUMMULS;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    state_t state, state_nxt;

    // Instruction operands held for the groups issued after the accept cycle
    logic [NUMLANES*WIDTH-1:0] opa_q, opb_q;
    logic [NUMLANES-1:0]       vmask_q;
    logic [2:0]                op_q;
    logic [LOG2WIDTH-1:0]      sh_q;
    logic [G-1:0]              rem_q;

    // Issue stage
    logic [NUMLANES*WIDTH-1:0] cur_a, cur_b;
    logic [NUMLANES-1:0]       cur_mask;
    logic [2:0]                cur_op;
    logic [LOG2WIDTH-1:0]      cur_sh;
    logic [G-1:0]              grp_act, rem_cur, pick, rem_after;
    logic [GW-1:0]             grp_idx;
    logic                      accept, issue, is_last, zero_now, stall_raw;
    logic [PW-1:0]             mul_prod [NUMMULS];

    // Stage 2: registered products of one group
    logic                      p_valid, p_first, p_last;
    logic [GW-1:0]             p_grp;
    logic [2:0]                p_op;
    logic [LOG2WIDTH-1:0]      p_sh;
    logic [NUMMULS-1:0]        p_lmask;
    logic [PW-1:0]             p_prod [NUMMULS];

    // Stage 3: result assembly
    logic [NUMLANES*WIDTH-1:0] acc_q, merged;
    logic                      zero_pend;

    // Destination bookkeeping pipe
    logic [REGIDBITS-1:0]      dst_s2, dst_s3;
    logic                      we_s2, we_s3;
    logic [NUMLANES-1:0]       mask_s2, mask_s3;

    logic                      unused_op_hi;
    assign unused_op_hi = ^op[4:3];

    // Shift/round selection applied to one full-width product at stage 3
    function automatic logic [WIDTH-1:0] post(input logic [PW-1:0] p, input logic [2:0] o,
                                              input logic [LOG2WIDTH-1:0] sh);
        logic [PW-1:0]        rnd;
        logic signed [PW-1:0] rsum;
        logic [WIDTH-1:0]     r;
        rnd  = (sh == '0) ? '0 : (PW'(1) << (sh - LOG2WIDTH'(1)));
        rsum = $signed(p + rnd);
        case (o)
            3'b010, 3'b011: r = p[PW-1:WIDTH];
            3'b100:         r = WIDTH'(rsum >>> sh);
            default:        r = p[WIDTH-1:0];
        endcase
        return r;
    endfunction

    // Group activity from the incoming mask
    always_comb begin
        for (int g = 0; g < G; g++) grp_act[g] = |vmask[g*NUMMULS +: NUMMULS];
    end

    // Operand source, priority group pick, issue control and stall
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cur_a = opA; cur_b = opB; cur_mask = vmask; cur_op = op[2:0]; cur_sh = vshamt;
        rem_cur = grp_act;
        if (state == BUSY) begin
            cur_a = opa_q; cur_b = opb_q; cur_mask = vmask_q; cur_op = op_q; cur_sh = sh_q;
            rem_cur = rem_q;
        end
        accept    = (state == IDLE) && activate && en[1] && !squash[1];
        pick      = rem_cur & (~rem_cur + G'(1));
        rem_after = rem_cur & ~pick;
        grp_idx   = '0;
        for (int g = 0; g < G; g++) if (pick[g]) grp_idx = GW'(g);
        issue     = (state == IDLE) ? (accept && (rem_cur != '0)) : (en[1] && !squash[1]);
        is_last   = issue && (rem_after == '0);
        zero_now  = accept && (rem_cur == '0);
        if (state == BUSY) stall_raw = !squash[1] && (!en[1] || (rem_after != '0));
        else               stall_raw = accept && (rem_after != '0);
        stall = resetn && stall_raw;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (rem_after != '0)) state_nxt = BUSY;
            BUSY:    if (squash[1] || (en[1] && (rem_after == '0))) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared multipliers: operands sign-extended to PW bits for the signed ops
    always_comb begin
        logic          sgn;
        logic [WIDTH-1:0] a_el, b_el;
        logic [PW-1:0] ax, bx;
        sgn = (cur_op != 3'b000) && (cur_op != 3'b010);
        for (int j = 0; j < NUMMULS; j++) begin
            a_el = cur_a[(int'(grp_idx)*NUMMULS + j)*WIDTH +: WIDTH];
            b_el = cur_b[(int'(grp_idx)*NUMMULS + j)*WIDTH +: WIDTH];
            ax = {{WIDTH{sgn & a_el[WIDTH-1]}}, a_el};
            bx = {{WIDTH{sgn & b_el[WIDTH-1]}}, b_el};
            mul_prod[j] = ax * bx;
        end
    end

    // Merge the stage-2 group into the result buffer
    always_comb begin
        merged = p_first ? '0 : acc_q;
        for (int j = 0; j < NUMMULS; j++)
            merged[(int'(p_grp)*NUMMULS + j)*WIDTH +: WIDTH] =
                p_lmask[j] ? post(p_prod[j], p_op, p_sh) : '0;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Operand latch on accept and remaining-groups vector on each issue
    always_ff @(posedge clk) begin
        if (!resetn) begin
            opa_q <= '0; opb_q <= '0; vmask_q <= '0; op_q <= '0; sh_q <= '0; rem_q <= '0;
        end else begin
            if (accept) begin
                opa_q <= opA; opb_q <= opB; vmask_q <= vmask; op_q <= op[2:0]; sh_q <= vshamt;
            end
            if (issue) rem_q <= rem_after;
        end
    end

    // Stage 2: capture the issued group's products
    always_ff @(posedge clk) begin
        if (!resetn) begin
            p_valid <= 1'b0; p_first <= 1'b0; p_last <= 1'b0;
            p_grp <= '0; p_op <= '0; p_sh <= '0; p_lmask <= '0;
            for (int j = 0; j < NUMMULS; j++) p_prod[j] <= '0;
        end else begin
            p_valid <= issue;
            if (issue) begin
                p_first <= accept;
                p_last  <= is_last;
                p_grp   <= grp_idx;
                p_op    <= cur_op;
                p_sh    <= cur_sh;
                p_lmask <= cur_mask[int'(grp_idx)*NUMMULS +: NUMMULS];
                for (int j = 0; j < NUMMULS; j++) p_prod[j] <= mul_prod[j];
            end
        end
    end

    // Stage 3: accumulate groups and publish the result on the last one.
    // An all-skipped instruction clears result directly; if that collides with
    // the previous instruction's final group, the clear is deferred one cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_q <= '0; result <= '0; zero_pend <= 1'b0;
        end else begin
            if (p_valid) acc_q <= merged;
            if (en[3]) begin
                if (p_valid && p_last)        result <= merged;
                else if (zero_now || zero_pend) result <= '0;
            end
            zero_pend <= zero_now && p_valid && p_last && en[3];
        end
    end

    // Destination id / write enable / mask pipe
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dst_s2 <= '0; we_s2 <= 1'b0; mask_s2 <= '0;
            dst_s3 <= '0; we_s3 <= 1'b0; mask_s3 <= '0;
        end else begin
            if (en[1] && !stall) begin
                dst_s2  <= in_dst;
                we_s2   <= in_dst_we && (accept || (state == BUSY && !squash[1]));
                mask_s2 <= cur_mask;
            end
            if (en[2]) begin
                dst_s3  <= dst_s2;
                we_s3   <= we_s2 && !squash[2];
                mask_s3 <= mask_s2;
            end
        end
    end

    assign out_dst      = {dst_s3, dst_s2};
    assign out_dst_we   = {we_s3 && !squash[3], we_s2 && !squash[2]};
    assign out_dst_mask = {mask_s3, mask_s2};
endmodule

// File: tb/tb_vmul_unit_seq.sv
// tb_vmul_unit_seq: directed vectors with hand-computed lane values.
module tb_vmul_unit_seq;
    localparam int NL = 8;
    localparam int W  = 32;

    logic              clk = 1'b0;
    logic              resetn;
    logic [4:0]        op;
    logic              activate;
    logic [3:1]        en, squash;
    logic [NL*W-1:0]   opA, opB;
    logic [4:0]        vshamt;
    logic [NL-1:0]     vmask;
    logic [9:0]        in_dst;
    logic              in_dst_we;
    logic              stall;
    logic [NL*W-1:0]   result;
    logic [19:0]       out_dst;
    logic [1:0]        out_dst_we;
    logic [15:0]       out_dst_mask;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [NL*W-1:0]   last_exp;

    always #5 clk = ~clk;

    vmul_unit_seq dut (
        .clk(clk), .resetn(resetn), .op(op), .activate(activate), .en(en), .squash(squash),
        .opA(opA), .opB(opB), .vshamt(vshamt), .vmask(vmask), .in_dst(in_dst),
        .in_dst_we(in_dst_we), .stall(stall), .result(result), .out_dst(out_dst),
        .out_dst_we(out_dst_we), .out_dst_mask(out_dst_mask)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] expv(input logic [31:0] v, input logic [7:0] m);
        logic [255:0] e;
        e = '0;
        for (int i = 0; i < NL; i++) if (m[i]) e[i*W +: W] = v;
        return e;
    endfunction

    // Issue one instruction, count stall cycles, then check stage-2/3 outputs
    task automatic do_op(input string name, input logic [4:0] o, input logic [31:0] a, b,
                         input logic [7:0] m, input logic [4:0] sh, input logic [9:0] d,
                         input logic [31:0] lane_exp, input int exp_stalls);
        int stalls;
        bit done;
        op = o; opA = {NL{a}}; opB = {NL{b}}; vmask = m; vshamt = sh;
        in_dst = d; in_dst_we = 1'b1; activate = 1'b1;
        stalls = 0; done = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            #1;
            if (stall) stalls++; else done = 1'b1;
            step();
        end
        activate = 1'b0; in_dst_we = 1'b0;
        check({name, "_done"}, 256'(done), 256'(1));
        check({name, "_stalls"}, 256'(stalls), 256'(exp_stalls));
        #1;
        check({name, "_we2"}, 256'(out_dst_we[0]), 256'(1));
        step();
        #1;
        last_exp = expv(lane_exp, m);
        check({name, "_result"}, result, last_exp);
        check({name, "_we3"}, 256'(out_dst_we[1]), 256'(1));
        check({name, "_dst3"}, 256'(out_dst[19:10]), 256'(d));
        check({name, "_mask3"}, 256'(out_dst_mask[15:8]), 256'(m));
    endtask

    initial begin
        resetn = 1'b0; en = 3'b111; squash = 3'b000; op = 5'd1; activate = 1'b1;
        opA = '0; opB = '0; vshamt = '0; vmask = 8'hFF; in_dst = 10'h3; in_dst_we = 1'b1;
        step(); step();
        #1;
        check("rst_stall", 256'(stall), 256'(0));
        check("rst_result", result, 256'(0));
        check("rst_we", 256'(out_dst_we), 256'(0));
        check("rst_dst", 256'(out_dst), 256'(0));
        check("rst_mask", 256'(out_dst_mask), 256'(0));
        activate = 1'b0; in_dst_we = 1'b0;
        step();
        resetn = 1'b1;
        step();

        // Signed low, both groups active
        do_op("t1_sl",   5'b00001, 32'hFFFFFFFD, 32'd7, 8'hFF, 5'd0, 10'h011, 32'hFFFFFFEB, 1);
        // Group skipping and per-lane masking
        do_op("t2_lo4",  5'b00001, 32'h00001234, 32'h10, 8'h0F, 5'd0, 10'h012, 32'h00012340, 0);
        do_op("t2_zero", 5'b00001, 32'h00001234, 32'h10, 8'h00, 5'd0, 10'h013, 32'h0, 0);
        do_op("t2_g1",   5'b00001, 32'd6, 32'd7, 8'hA0, 5'd0, 10'h014, 32'h0000002A, 0);
        do_op("t2_edge", 5'b00001, 32'd6, 32'd7, 8'h81, 5'd0, 10'h015, 32'h0000002A, 1);
        // High halves, unsigned low, aliased encodings
        do_op("t3_uhi",  5'b00010, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 5'd0, 10'h016, 32'hFFFFFFFE, 1);
        do_op("t3_shi",  5'b00011, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 5'd0, 10'h017, 32'h00000000, 1);
        do_op("t3_ulo",  5'b00000, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 5'd0, 10'h018, 32'h00000001, 1);
        do_op("t3_alias",5'b11111, 32'hFFFFFFFD, 32'd7, 8'hFF, 5'd0, 10'h019, 32'hFFFFFFEB, 1);
        // Fixed point with rounding
        do_op("t4_fx16", 5'b00100, 32'h00010000, 32'h00018000, 8'hFF, 5'd16, 10'h01A, 32'h00018000, 1);
        do_op("t4_rnd",  5'b00100, 32'd3, 32'd1, 8'hFF, 5'd1, 10'h01B, 32'd2, 1);
        do_op("t4_neg",  5'b00100, 32'hFFFFFFFD, 32'd1, 8'hFF, 5'd1, 10'h01C, 32'hFFFFFFFF, 1);
        do_op("t4_sh0",  5'b00100, 32'd5, 32'hFFFFFFFE, 8'hFF, 5'd0, 10'h01D, 32'hFFFFFFF6, 1);

        // Squash during stall: abort, no writeback, result untouched
        op = 5'd1; opA = {NL{32'd2}}; opB = {NL{32'd3}}; vmask = 8'hFF; vshamt = '0;
        in_dst = 10'h020; in_dst_we = 1'b1; activate = 1'b1;
        #1 check("sq_stall_T", 256'(stall), 256'(1));
        step();
        squash = 3'b001;
        #1 check("sq_stall_sq", 256'(stall), 256'(0));
        step();
        squash = 3'b000; activate = 1'b0; in_dst_we = 1'b0;
        #1 check("sq_stall_after", 256'(stall), 256'(0));
        for (int c = 0; c < 3; c++) begin
            check("sq_we", 256'(out_dst_we), 256'(0));
            check("sq_result", result, last_exp);
            step();
            #1;
        end

        // Reset in the middle of a sequence
        in_dst_we = 1'b1; activate = 1'b1;
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1; activate = 1'b0; in_dst_we = 1'b0;
        #1;
        check("mr_result", result, 256'(0));
        check("mr_we", 256'(out_dst_we), 256'(0));
        check("mr_stall", 256'(stall), 256'(0));
        check("mr_mask", 256'(out_dst_mask), 256'(0));
        step();
        do_op("mr_next", 5'b00000, 32'd5, 32'd6, 8'hFF, 5'd0, 10'h021, 32'h0000001E, 1);

        // Back-to-back with en[1] dropped for 2 cycles in BUSY
        op = 5'd1; opA = {NL{32'hFFFFFFFD}}; opB = {NL{32'd7}}; vmask = 8'hFF;
        in_dst = 10'h011; in_dst_we = 1'b1; activate = 1'b1;
        #1 check("bb_c0_stall", 256'(stall), 256'(1));
        step();
        en = 3'b110;
        #1 check("bb_c1_stall", 256'(stall), 256'(1));
        step();
        #1 check("bb_c2_stall", 256'(stall), 256'(1));
        step();
        en = 3'b111;
        #1 check("bb_c3_stall", 256'(stall), 256'(0));
        step();
        op = 5'd0; opA = {NL{32'd100}}; opB = {NL{32'd200}}; in_dst = 10'h022;
        #1;
        check("bb_c4_stall", 256'(stall), 256'(1));
        check("bb_c4_we2", 256'(out_dst_we[0]), 256'(1));
        check("bb_c4_dst2", 256'(out_dst[9:0]), 256'(10'h011));
        step();
        #1;
        check("bb_c5_stall", 256'(stall), 256'(0));
        check("bb_c5_resA", result, expv(32'hFFFFFFEB, 8'hFF));
        check("bb_c5_dst3", 256'(out_dst[19:10]), 256'(10'h011));
        step();
        activate = 1'b0; in_dst_we = 1'b0;
        step();
        #1;
        check("bb_c7_resB", result, expv(32'h00004E20, 8'hFF));
        check("bb_c7_dst3", 256'(out_dst[19:10]), 256'(10'h022));
        check("bb_c7_we3", 256'(out_dst_we[1]), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
